// File: rtl/col_sched_pkg.sv
// Shared types and defaults for the column bank scheduler.
package col_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} col_sched_state_t;

  localparam int RD_LAT_DEF = 2;

endpackage

// File: rtl/col_sched_vld_pipe.sv
// RD_LAT-deep read-valid shift register; flags when no younger beat is in flight.
module col_sched_vld_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flag,
  output logic out_valid,
  output logic empty
);

  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] younger;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_pipe <= '0;
    else        vld_pipe <= (vld_pipe << 1) | RD_LAT'(flag);
  end

  assign out_valid = vld_pipe[RD_LAT-1];
  // Everything except the beat presented this cycle; zero means this is the last one.
  assign younger   = vld_pipe & ~(RD_LAT'(1) << (RD_LAT-1));
  assign empty     = ~flag & ~|younger;

endmodule

// File: rtl/column_bank_scheduler.sv
// Fills NUM_COL banks column by column, then drains them in lockstep as rows.
// Optional sticky err output for protocol misuse when COL_SCHED_ERR_EN is defined.
module column_bank_scheduler
  import col_sched_pkg::*;
#(
  parameter int NUM_COL    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_WIDTH:0]           cfg_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [NUM_COL-1:0]            bank_wr_req,
  output logic [DATA_WIDTH-1:0]         bank_wr_data,
  output logic [NUM_COL-1:0]            bank_rd_req,
  output logic [NUM_COL-1:0]            bank_rd_flag,
  input  logic [NUM_COL*DATA_WIDTH-1:0] bank_rd_data,
  output logic                          out_valid,
  output logic [NUM_COL*DATA_WIDTH-1:0] out_data,
  output logic                          busy,
  output logic                          done
`ifdef COL_SCHED_ERR_EN
  ,output logic                         err
`endif
);

  localparam int CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  col_sched_state_t    state;
  logic [ADDR_WIDTH:0] len_q;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [ADDR_WIDTH:0] rd_cnt;
  logic [CW-1:0]       col;
  logic                len_ok;
  logic                accept;
  logic                rd_on;
  logic                pipe_empty;

  assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_MAX);
  assign in_ready = (state == S_FILL);
  assign accept   = in_ready & in_valid;
  assign rd_on    = (state == S_DRAIN) && (rd_cnt != len_q);
  assign busy     = (state == S_FILL) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

  assign bank_wr_req  = accept ? (NUM_COL'(1) << col) : '0;
  assign bank_wr_data = in_ready ? in_data : '0;
  assign bank_rd_req  = {NUM_COL{rd_on}};
  assign bank_rd_flag = {NUM_COL{rd_on}};
  assign out_data     = out_valid ? bank_rd_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      rd_cnt   <= '0;
      col      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start && len_ok) begin
          len_q    <= cfg_len;
          word_cnt <= '0;
          rd_cnt   <= '0;
          col      <= '0;
          state    <= S_FILL;
        end
        S_FILL: if (accept) begin
          if (word_cnt == len_q - 1'b1) begin
            word_cnt <= '0;
            if (col == CW'(NUM_COL-1)) begin
              col   <= '0;
              state <= S_DRAIN;
            end else begin
              col <= col + 1'b1;
            end
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        // Flags run len_q cycles; then hold until the last row leaves the pipe.
        S_DRAIN: begin
          if (rd_cnt != len_q)  rd_cnt <= rd_cnt + 1'b1;
          else if (pipe_empty)  state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  col_sched_vld_pipe #(.RD_LAT(RD_LAT)) u_vld_pipe (
    .clk       (clk),
    .reset     (reset),
    .flag      (rd_on),
    .out_valid (out_valid),
    .empty     (pipe_empty)
  );

`ifdef COL_SCHED_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else if ((start && busy) ||
             (start && (state == S_IDLE) && !len_ok) ||
             (in_valid && ((state == S_IDLE) || (state == S_DRAIN))))
      err <= 1'b1;
  end
`endif

endmodule
